oam_scan: RTL and testbench
===========================

Name: oam_scan

Overview:
- Per-scanline sprite evaluator for the PPU.
- Replaces the per-pixel combinational search over all sprites.
- During mode 2, walks OAM sequentially. Selects up to MAX_PER_LINE sprites that intersect the current line, in OAM index order. Supports 8x8 and 8x16 sprite heights.
- Latches the selected sprites, with pre-computed tile row, into a slot file that the mode-3 pixel pipeline reads by slot number.

Parameters:
- SPRITE_COUNT, 40: number of OAM entries scanned.
- MAX_PER_LINE, 10: slot file depth; this is the per-line hardware sprite limit.
- CYCLES_PER_ENTRY, 2: clocks spent per OAM entry (>=1); fixes scan length at SPRITE_COUNT*CYCLES_PER_ENTRY.
- IDX_W, 6: OAM index width; must satisfy 2^IDX_W >= SPRITE_COUNT.
- SLOT_W, 4: slot index/count width; must satisfy 2^SLOT_W > MAX_PER_LINE.

Ports:
- clockgb  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse at mode-2 entry; begins a scan.
- line  in  8  current LY, sampled on start.
- tall  in  1  LCDC[2]; 1 = 8x16 sprites; sampled on start.
- enable  in  1  LCDC[1]; sampled on start.
- oam_index  out  IDX_W  OAM entry being fetched.
- oam_y, oam_x, oam_tile, oam_attr  in  8 each  OAM entry data; valid one cycle after oam_index.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the slot file is complete.
- count  out  SLOT_W  number of valid slots.
- overflow  out  1  more than MAX_PER_LINE sprites hit this line.
- slot_sel  in  SLOT_W  renderer slot query.
- slot_valid  out  1  slot_sel < count.
- slot_x  out  8  raw OAM X of the selected slot.
- slot_tile  out  8  tile number with row bit folded in (8x16).
- slot_row  out  3  row within the tile, flip applied.
- slot_attr  out  8  raw OAM attribute byte.

Behaviour:
- Reset: busy=0, done=0, count=0, overflow=0, oam_index=0, state IDLE, all slot entries cleared to 0.
- States: IDLE, SCAN, DONE.
  - IDLE: start moves to SCAN.
  - SCAN: lasts exactly SPRITE_COUNT*CYCLES_PER_ENTRY cycles, then moves to DONE.
  - DONE: lasts one cycle (done=1), then returns to IDLE.
- Start edge T:
  - Latch line, tall, enable.
  - Clear count and overflow.
  - Set oam_index=0.
  - busy goes to 1 at T+1.
- oam_index advances by 1 every CYCLES_PER_ENTRY cycles. Entry k's data is evaluated on the cycle after its index is presented.
- done asserts at T+SPRITE_COUNT*CYCLES_PER_ENTRY+1 (81 with defaults). busy deasserts in the same cycle. count and overflow are final when done asserts.
- Hit test: h = tall?16:8; d = (line + 16 - oam_y) mod 256. Hit iff d < h.
  - oam_x is not considered: X=0 or X>=168 still consumes a slot.
- Row compute:
  - r = attr[6] ? (h-1-d) : d.
  - slot_row = r[2:0].
  - slot_tile = tall ? {oam_tile[7:1], r[3]} : oam_tile.
- On a hit:
  - count < MAX_PER_LINE: write slot[count], increment count.
  - Otherwise: drop the sprite and set overflow=1. Slot contents are unchanged.
- enable=0 at start: full-length scan still runs and done still pulses; nothing is stored, count=0, overflow=0.
- start during SCAN: restarts the scan from index 0 with new samples. Previous partial results are discarded (count cleared).
- start in the same cycle as the last SCAN cycle: restart takes precedence; done is not pulsed.
- Slot reads are combinational from the slot registers.
  - Slot contents persist after done until the next start clears count.
  - slot_valid=0 and outputs are don't-care when slot_sel >= count.
- Asynchronous reset mid-scan: immediately returns to the reset state; no done pulse.
- Widths: all Y/X arithmetic is 8-bit wraparound; d is compared as unsigned 8-bit.

Decomposition:
- ppu_pkg holds:
  - OAM attribute bit positions (PRI=7, YFLIP=6, XFLIP=5, PAL=4).
  - SPRITE_Y_OFFSET=16 and SPRITE_X_OFFSET=8.
  - Scan state enum.
  - Packed slot-entry struct {x, tile, row, attr}.
- One sub-module, oam_match: combinational; takes line, tall and the OAM entry; produces hit, slot_tile and slot_row. It is reused by any future window/object-fetch logic.

Test Plan:
- Sprite 0 at Y=16, X=8, tile 0x12, attr 0; line=0, tall=0 → done at cycle 81; count=1; slot0 x=8, tile=0x12, row=0.
- 12 sprites with Y=20 at indices 3..14, line=5 → count=10; slots hold indices 3..12 in order; overflow=1; row=1 each.
- tall=1, Y=16, tile 0x35, attr YFLIP, line=3 → d=3, r=12; slot_tile=0x35; slot_row=4.
- Y=0 (d wraps to 16), line=0, tall=1 → no hit, count=0. Same setup with Y=2 → hit, row 14 (slot_row=6), slot_tile bit0=1.
- enable=0 with 5 matching sprites → done at 81, count=0, overflow=0, slot_valid=0 for sel=0.
- start re-pulsed at cycle 40 of a scan → done only at 40+81; count reflects the second scan only. resetn dropped mid-scan → busy=0, count=0, no done.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM attribute layout, sprite coordinate offsets,
// scan state encoding and the slot-file entry format.
`default_nettype none

package ppu_pkg;

  localparam int ATTR_PRI   = 7;
  localparam int ATTR_YFLIP = 6;
  localparam int ATTR_XFLIP = 5;
  localparam int ATTR_PAL   = 4;

  localparam logic [7:0] SPRITE_Y_OFFSET = 8'd16;
  localparam logic [7:0] SPRITE_X_OFFSET = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] tile;
    logic [2:0] row;
    logic [7:0] attr;
  } slot_t;

endpackage

`default_nettype wire

// File: rtl/oam_match.sv
// Combinational sprite/scanline intersection test with tile-row computation
// (Y flip and 8x16 tile-pair selection folded in).
`default_nettype none

module oam_match
  import ppu_pkg::*;
(
  input  logic [7:0] line_i,
  input  logic       tall_i,
  input  logic [7:0] y_i,
  input  logic [7:0] tile_i,
  input  logic       yflip_i,
  output logic       hit_o,
  output logic [7:0] tile_o,
  output logic [2:0] row_o
);

  logic [7:0] d;
  logic [7:0] h;
  logic [3:0] r;

  always_comb begin
    h     = tall_i ? 8'd16 : 8'd8;
    d     = line_i + SPRITE_Y_OFFSET - y_i;
    hit_o = (d < h);
    // Only meaningful on a hit (d < 16), so 4-bit arithmetic suffices.
    r      = yflip_i ? (h[3:0] - 4'd1 - d[3:0]) : d[3:0];
    row_o  = r[2:0];
    tile_o = tall_i ? {tile_i[7:1], r[3]} : tile_i;
  end

endmodule

`default_nettype wire

// File: rtl/oam_scan.sv
// Mode-2 sprite evaluator: walks OAM once per line and latches up to
// MAX_PER_LINE intersecting sprites into a slot file read by the renderer.
`default_nettype none

module oam_scan
  import ppu_pkg::*;
#(
  parameter int unsigned SPRITE_COUNT     = 40,
  parameter int unsigned MAX_PER_LINE     = 10,
  parameter int unsigned CYCLES_PER_ENTRY = 2,
  parameter int unsigned IDX_W            = 6,
  parameter int unsigned SLOT_W           = 4
) (
  input  logic              clockgb,
  input  logic              resetn,
  input  logic              start,
  input  logic [7:0]        line,
  input  logic              tall,
  input  logic              enable,
  output logic [IDX_W-1:0]  oam_index,
  input  logic [7:0]        oam_y,
  input  logic [7:0]        oam_x,
  input  logic [7:0]        oam_tile,
  input  logic [7:0]        oam_attr,
  output logic              busy,
  output logic              done,
  output logic [SLOT_W-1:0] count,
  output logic              overflow,
  input  logic [SLOT_W-1:0] slot_sel,
  output logic              slot_valid,
  output logic [7:0]        slot_x,
  output logic [7:0]        slot_tile,
  output logic [2:0]        slot_row,
  output logic [7:0]        slot_attr
);

  localparam int unsigned TOTAL = SPRITE_COUNT * CYCLES_PER_ENTRY;
  localparam int unsigned CYC_W = $clog2(TOTAL + 1);
  localparam int unsigned SUB_W = (CYCLES_PER_ENTRY > 1) ? $clog2(CYCLES_PER_ENTRY) : 1;

  scan_state_e       state_q, state_d;
  logic [CYC_W-1:0]  cyc_q;
  logic [SUB_W-1:0]  sub_q;
  logic [IDX_W-1:0]  idx_q;
  logic              eval_q;
  logic [7:0]        line_q;
  logic              tall_q;
  logic              en_q;
  logic [SLOT_W-1:0] count_q;
  logic              ovf_q;
  slot_t             slots_q [MAX_PER_LINE];

  logic       scan_last;
  logic       m_hit;
  logic [7:0] m_tile;
  logic [2:0] m_row;
  logic       hit_valid;
  logic       take;
  logic       drop;
  slot_t      rd_slot;

  oam_match u_match (
    .line_i  (line_q),
    .tall_i  (tall_q),
    .y_i     (oam_y),
    .tile_i  (oam_tile),
    .yflip_i (oam_attr[ATTR_YFLIP]),
    .hit_o   (m_hit),
    .tile_o  (m_tile),
    .row_o   (m_row)
  );

  assign scan_last = (state_q == ST_SCAN) && (cyc_q == CYC_W'(TOTAL - 1));
  assign hit_valid = eval_q && en_q && m_hit;
  assign take      = hit_valid && (count_q < SLOT_W'(MAX_PER_LINE));
  assign drop      = hit_valid && !take;

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A start pulse wins over every transition, including the final SCAN cycle.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_SCAN;
    end else begin
      case (state_q)
        ST_SCAN: if (scan_last) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == ST_SCAN);
    done = (state_q == ST_DONE);
  end

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      cyc_q   <= '0;
      sub_q   <= '0;
      idx_q   <= '0;
      eval_q  <= 1'b0;
      line_q  <= '0;
      tall_q  <= 1'b0;
      en_q    <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (start) begin
      cyc_q   <= '0;
      sub_q   <= '0;
      idx_q   <= '0;
      eval_q  <= 1'b0;
      line_q  <= line;
      tall_q  <= tall;
      en_q    <= enable;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == ST_SCAN) begin
        cyc_q  <= cyc_q + CYC_W'(1);
        // OAM data lands one cycle after the index's first presentation.
        eval_q <= (sub_q == '0);
        if (sub_q == SUB_W'(CYCLES_PER_ENTRY - 1)) begin
          sub_q <= '0;
          if (!scan_last) idx_q <= idx_q + IDX_W'(1);
        end else begin
          sub_q <= sub_q + SUB_W'(1);
        end
      end else begin
        eval_q <= 1'b0;
      end
      if (take) count_q <= count_q + SLOT_W'(1);
      if (drop) ovf_q   <= 1'b1;
    end
  end

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(MAX_PER_LINE); i++) slots_q[i] <= '0;
    end else if (!start && take) begin
      for (int i = 0; i < int'(MAX_PER_LINE); i++) begin
        if (count_q == SLOT_W'(i)) begin
          slots_q[i] <= '{x: oam_x, tile: m_tile, row: m_row, attr: oam_attr};
        end
      end
    end
  end

  always_comb begin
    rd_slot = '0;
    for (int i = 0; i < int'(MAX_PER_LINE); i++) begin
      if (slot_sel == SLOT_W'(i)) rd_slot = slots_q[i];
    end
  end

  assign oam_index  = idx_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign slot_valid = (slot_sel < count_q);
  assign slot_x     = rd_slot.x;
  assign slot_tile  = rd_slot.tile;
  assign slot_row   = rd_slot.row;
  assign slot_attr  = rd_slot.attr;

endmodule

`default_nettype wire

// File: tb/tb_oam_scan.sv
// Self-checking bench for oam_scan: directed vector table, randomized scans
// against a line-coverage reference model, and restart/reset sequences.
`default_nettype none

module tb_oam_scan;

  logic       clockgb = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] line;
  logic       tall;
  logic       enable;
  logic [5:0] oam_index;
  logic [7:0] oam_y, oam_x, oam_tile, oam_attr;
  logic       busy, done;
  logic [3:0] count;
  logic       overflow;
  logic [3:0] slot_sel;
  logic       slot_valid;
  logic [7:0] slot_x, slot_tile;
  logic [2:0] slot_row;
  logic [7:0] slot_attr;

  logic [7:0] my [64];
  logic [7:0] mx [64];
  logic [7:0] mt [64];
  logic [7:0] ma [64];

  int checks = 0;
  int errors = 0;

  always #5 clockgb = ~clockgb;

  // OAM RAM with a registered read port: data valid the cycle after the index.
  always @(posedge clockgb) begin
    oam_y    <= my[oam_index];
    oam_x    <= mx[oam_index];
    oam_tile <= mt[oam_index];
    oam_attr <= ma[oam_index];
  end

  oam_scan dut (
    .clockgb    (clockgb),
    .resetn     (resetn),
    .start      (start),
    .line       (line),
    .tall       (tall),
    .enable     (enable),
    .oam_index  (oam_index),
    .oam_y      (oam_y),
    .oam_x      (oam_x),
    .oam_tile   (oam_tile),
    .oam_attr   (oam_attr),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .overflow   (overflow),
    .slot_sel   (slot_sel),
    .slot_valid (slot_valid),
    .slot_x     (slot_x),
    .slot_tile  (slot_tile),
    .slot_row   (slot_row),
    .slot_attr  (slot_attr)
  );

  typedef struct {
    logic [7:0] ln;
    logic       t;
    logic       en;
    logic [7:0] y;
    logic [7:0] tile;
    logic [7:0] attr;
    int         first;
    int         n;
    int         exp_count;
    logic       exp_ovf;
    logic [7:0] exp_tile0;
    logic [2:0] exp_row0;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_idle();
    for (int k = 0; k < 64; k++) begin
      my[k] = 8'd200;
      mx[k] = 8'(8 + k);
      mt[k] = 8'(k);
      ma[k] = 8'h00;
    end
  endtask

  // Returns #1 after the edge that samples start (cycle 1 of the scan).
  task automatic pulse_start(input logic [7:0] l, input logic t, input logic e);
    line   = l;
    tall   = t;
    enable = e;
    start  = 1'b1;
    @(posedge clockgb);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    bit found;
    found = 1'b0;
    edges = 0;
    while (!found && edges < 400) begin
      @(posedge clockgb);
      #1;
      edges++;
      if (done) found = 1'b1;
    end
    if (!found) edges = -1;
  endtask

  task automatic watch_no_done(input int n, output bit saw);
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clockgb);
      #1;
      if (done) saw = 1'b1;
    end
  endtask

  initial begin
    int  e;
    bit  saw;
    int  q[$];
    int  exp_cnt;
    int  last_cnt;
    bit  exp_ovf;

    resetn   = 1'b0;
    start    = 1'b0;
    line     = 8'd0;
    tall     = 1'b0;
    enable   = 1'b0;
    slot_sel = 4'd0;
    fill_idle();

    //          ln    t     en    y      tile   attr  first n  cnt ovf tile0  row0
    tbl[0] = '{8'd0,  1'b0, 1'b1, 8'd16, 8'h12, 8'h00, 0,  1,  1, 1'b0, 8'h12, 3'd0};
    tbl[1] = '{8'd5,  1'b0, 1'b1, 8'd20, 8'h40, 8'h00, 3,  12, 10, 1'b1, 8'h40, 3'd1};
    tbl[2] = '{8'd3,  1'b1, 1'b1, 8'd16, 8'h35, 8'h40, 0,  1,  1, 1'b0, 8'h35, 3'd4};
    tbl[3] = '{8'd0,  1'b1, 1'b1, 8'd0,  8'h34, 8'h00, 0,  1,  0, 1'b0, 8'h00, 3'd0};
    tbl[4] = '{8'd0,  1'b1, 1'b1, 8'd2,  8'h34, 8'h00, 5,  1,  1, 1'b0, 8'h35, 3'd6};
    tbl[5] = '{8'd5,  1'b0, 1'b0, 8'd20, 8'h40, 8'h00, 0,  5,  0, 1'b0, 8'h00, 3'd0};
    tbl[6] = '{8'd7,  1'b0, 1'b1, 8'd16, 8'h21, 8'h40, 39, 1,  1, 1'b0, 8'h21, 3'd0};
    tbl[7] = '{8'd8,  1'b0, 1'b1, 8'd16, 8'h21, 8'h00, 0,  1,  0, 1'b0, 8'h00, 3'd0};
    tbl[8] = '{8'd10, 1'b0, 1'b1, 8'd20, 8'h80, 8'h00, 30, 10, 10, 1'b0, 8'h80, 3'd6};
    tbl[9] = '{8'd15, 1'b1, 1'b1, 8'd16, 8'h34, 8'hB0, 0,  1,  1, 1'b0, 8'h35, 3'd7};

    repeat (2) @(posedge clockgb);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_oam_index", 32'(oam_index), 32'd0);
    chk("rst_slot_valid", 32'(slot_valid), 32'd0);
    chk("rst_slot0", 32'({slot_x, slot_tile, slot_row, slot_attr}), 32'd0);
    resetn = 1'b1;
    @(posedge clockgb);
    #1;

    // Directed vectors
    for (int v = 0; v < NV; v++) begin
      fill_idle();
      for (int k = tbl[v].first; k < tbl[v].first + tbl[v].n; k++) begin
        my[k] = tbl[v].y;
        mt[k] = tbl[v].tile;
        ma[k] = tbl[v].attr;
      end
      pulse_start(tbl[v].ln, tbl[v].t, tbl[v].en);
      chk($sformatf("v%0d_busy_after_start", v), 32'(busy), 32'd1);
      wait_done(e);
      chk($sformatf("v%0d_done_cycle", v), 32'(e + 1), 32'd81);
      chk($sformatf("v%0d_busy_at_done", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_count", v), 32'(count), 32'(tbl[v].exp_count));
      chk($sformatf("v%0d_overflow", v), 32'(overflow), 32'(tbl[v].exp_ovf));
      for (int i = 0; i < tbl[v].exp_count; i++) begin
        slot_sel = 4'(i);
        #1;
        chk($sformatf("v%0d_slot%0d_x", v, i), 32'(slot_x), 32'(8 + tbl[v].first + i));
        if (i == 0) begin
          chk($sformatf("v%0d_slot0_tile", v), 32'(slot_tile), 32'(tbl[v].exp_tile0));
          chk($sformatf("v%0d_slot0_row", v), 32'(slot_row), 32'(tbl[v].exp_row0));
          chk($sformatf("v%0d_slot0_attr", v), 32'(slot_attr), 32'(tbl[v].attr));
        end
        chk($sformatf("v%0d_slot%0d_valid", v, i), 32'(slot_valid), 32'd1);
      end
      slot_sel = 4'(tbl[v].exp_count);
      #1;
      chk($sformatf("v%0d_valid_at_count", v), 32'(slot_valid), 32'd0);
    end

    // Randomized scans against a sprite-coverage model
    for (int it = 0; it < 25; it++) begin
      logic [7:0] ln;
      logic       t, en;
      int         hh;
      ln = 8'($urandom_range(0, 255));
      t  = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 7) != 0);
      hh = t ? 16 : 8;
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 2) == 0) my[k] = 8'($urandom);
        else                           my[k] = 8'(int'(ln) + 16 - int'($urandom_range(0, 18)));
        mx[k] = 8'($urandom);
        mt[k] = 8'($urandom);
        ma[k] = 8'($urandom);
      end
      // A sprite covers screen rows top .. top+h-1 (mod 256), top = Y - 16.
      q.delete();
      for (int k = 0; k < 40; k++) begin
        int top, dd;
        top = (int'(my[k]) - 16 + 256) % 256;
        dd  = (int'(ln) - top + 256) % 256;
        if (en && dd < hh) q.push_back(k);
      end
      exp_cnt = (q.size() > 10) ? 10 : q.size();
      exp_ovf = (q.size() > 10);

      pulse_start(ln, t, en);
      wait_done(e);
      chk($sformatf("r%0d_done_cycle", it), 32'(e + 1), 32'd81);
      chk($sformatf("r%0d_count", it), 32'(count), 32'(exp_cnt));
      chk($sformatf("r%0d_overflow", it), 32'(overflow), 32'(exp_ovf));
      for (int i = 0; i < exp_cnt; i++) begin
        int k, top, dd, rr;
        logic [7:0] et;
        k   = q[i];
        top = (int'(my[k]) - 16 + 256) % 256;
        dd  = (int'(ln) - top + 256) % 256;
        rr  = ma[k][6] ? (hh - 1 - dd) : dd;
        et  = t ? 8'((int'(mt[k]) & 8'hFE) + rr / 8) : mt[k];
        slot_sel = 4'(i);
        #1;
        chk($sformatf("r%0d_slot%0d", it, i),
            32'({slot_valid, slot_x, slot_tile, slot_row, slot_attr}),
            32'({1'b1, mx[k], et, 3'(rr % 8), ma[k]}));
      end
      slot_sel = 4'(exp_cnt);
      #1;
      chk($sformatf("r%0d_valid_at_count", it), 32'(slot_valid), 32'd0);
      last_cnt = exp_cnt;
    end

    repeat (5) @(posedge clockgb);
    #1;
    chk("persist_count", 32'(count), 32'(last_cnt));

    // Restart at cycle 40: first-line hits at 0..2, second-line hits at 30..31
    fill_idle();
    for (int k = 0; k < 3; k++) my[k] = 8'd30;
    my[30] = 8'd60;
    my[31] = 8'd60;
    pulse_start(8'd20, 1'b0, 1'b1);
    watch_no_done(39, saw);
    chk("restart40_partial_count", 32'(count), 32'd3);
    pulse_start(8'd50, 1'b0, 1'b1);
    chk("restart40_no_early_done", 32'(saw), 32'd0);
    wait_done(e);
    chk("restart40_done_cycle", 32'(40 + e + 1), 32'd121);
    chk("restart40_count", 32'(count), 32'd2);
    slot_sel = 4'd0;
    #1;
    chk("restart40_slot0_x", 32'(slot_x), 32'd38);

    // Restart coinciding with the last SCAN cycle suppresses done
    pulse_start(8'd20, 1'b0, 1'b1);
    watch_no_done(79, saw);
    pulse_start(8'd50, 1'b0, 1'b1);
    chk("restart80_no_done_before", 32'(saw), 32'd0);
    chk("restart80_no_done_pulse", 32'(done), 32'd0);
    chk("restart80_busy", 32'(busy), 32'd1);
    wait_done(e);
    chk("restart80_done_cycle", 32'(80 + e + 1), 32'd161);
    chk("restart80_count", 32'(count), 32'd2);

    // Asynchronous reset mid-scan
    pulse_start(8'd20, 1'b0, 1'b1);
    watch_no_done(30, saw);
    chk("midrst_count_before", 32'(count), 32'd3);
    resetn = 1'b0;
    #1;
    slot_sel = 4'd0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_oam_index", 32'(oam_index), 32'd0);
    chk("midrst_slot_valid", 32'(slot_valid), 32'd0);
    chk("midrst_slot0_cleared", 32'({slot_x, slot_tile, slot_row, slot_attr}), 32'd0);
    @(posedge clockgb);
    #1 resetn = 1'b1;
    watch_no_done(100, saw);
    chk("midrst_no_done", 32'(saw), 32'd0);
    chk("midrst_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
